ddr3_burst_arbiter: RTL
=======================

# ddr3_burst_arbiter

Sequences the single DDR3 IP user port between a write requester (show-ahead write FIFO, 256-bit side) and a read requester (read FIFO, 256-bit side), all in the `ui_clk` domain. It issues bursts of single-beat commands, generates wrapping addresses per port and guarantees read-FIFO space before any read is issued. It sits between the FIFO pair and the DDR3 memory interface top, replacing ad-hoc command sequencing in the adapter.

## Interface
- `ADDR_W`, 29: DDR3 user address width.
- `DATA_W`, 256: user data width; one beat per command.
- `LVL_W`, 10: FIFO level/space width.
- `ADDR_STEP`, 8: address increment per command.
- `ui_clk  in  1`: DDR3 user clock; the only clock.
- `rst_n  in  1`: reset; synchronous, active-low.
- `init_calib_complete  in  1`: no grant while low.
- `wr_load`, `rd_load  in  1`: one-cycle pulse, already in `ui_clk`; rewinds that port's pointer to its min.
- `app_addr_wr_min`, `app_addr_wr_max`, `app_addr_rd_min`, `app_addr_rd_max  in  ADDR_W`: regions are [min, max).
- `wr_bust_len`, `rd_bust_len  in  8`: commands per burst; 0 disables the port.
- `wr_level  in  LVL_W`: words available in the write FIFO.
- `wr_fifo_dout  in  DATA_W`: show-ahead head word.
- `wr_fifo_rden  out  1`: pop.
- `rd_space  in  LVL_W`: free words in the read FIFO.
- `rd_fifo_wren  out  1`, `rd_fifo_din  out  DATA_W`: read data push.
- `app_rdy`, `app_wdf_rdy`, `app_rd_data_valid  in  1`; `app_rd_data  in  DATA_W`.
- `app_en`, `app_wdf_wren`, `app_wdf_end  out  1`; `app_cmd  out  3`; `app_addr  out  ADDR_W`; `app_wdf_data  out  DATA_W`.
- `busy  out  1`: state ≠ IDLE.

## Operation
- FSM states: IDLE, WR_BURST, RD_BURST.
- Write eligibility: `wr_bust_len≠0 && wr_level ≥ wr_bust_len`.
- Read eligibility: `rd_bust_len≠0 && rd_space ≥ rd_bust_len + rd_pend`.
  - `rd_pend` counts read commands accepted whose data has not yet returned.
  - +1 on read accept, −1 on `app_rd_data_valid`; both in the same cycle leaves it unchanged.
  - Width LVL_W+1, never wraps.
- IDLE → grant only when `init_calib_complete`. If both ports are eligible, the one not served last wins; `last_grant` resets to READ, so write wins first.
- WR_BURST accept condition: `app_rdy && app_wdf_rdy`. In an accept cycle, all of these are asserted together, combinationally:
  - `app_en=1`, `app_cmd=0`, `app_wdf_wren=1`, `app_wdf_end=1`, `wr_fifo_rden=1`.
  - `app_wdf_data=wr_fifo_dout`.
- RD_BURST accept condition: `app_rdy`. In an accept cycle, `app_en=1` and `app_cmd=1`.
- `app_en` is never asserted without acceptance.
- Burst counter increments per accept; after the `bust_len`-th accept the FSM returns to IDLE. The burst is never aborted.
- Address generation per port, on each accept:
  - `next = ptr+ADDR_STEP`; if `next ≥ max`, wrap to min.
  - `app_addr` shows the read pointer in RD_BURST and the write pointer otherwise.
- Load handling:
  - In IDLE, or for the port not currently bursting, a load takes effect the next cycle.
  - For the bursting port, a load is held pending and applied on the cycle the FSM enters IDLE.
  - Load and the final accept in the same cycle: the load wins.
- `bust_len` and min/max are sampled at grant time and held for the whole burst.

## Timing
- Reset values:
  - state IDLE, `rd_pend=0`, counters 0, `last_grant=READ`.
  - Pointers = their respective min.
  - All strobes 0, `app_cmd=0`, `app_addr=app_addr_wr_min`, `rd_fifo_din=0`, `busy=0`.
- Eligibility at cycle N → burst state at N+1; first possible accept at N+1.
- Back-to-back accepts are possible every cycle while the ready inputs stay high.
- Last accept at cycle M → IDLE at M+1 → next burst state no earlier than M+2.
- `rd_fifo_wren`/`rd_fifo_din` are registered copies of `app_rd_data_valid`/`app_rd_data`, with 1-cycle latency.
- `rst_n` low mid-burst → IDLE next edge. Outstanding read data arriving after reset is still forwarded, but `rd_pend` stays at 0.

## Configuration
- `DDR_ARB_WR_PRIORITY_EN` defined: write always wins when both ports are eligible, so the camera input never stalls; `last_grant` is not used.
- Not defined: round-robin as described above.

## Structure
- Package `ddr_arb_pkg` holds:
  - State enum.
  - `CMD_WR=3'd0`, `CMD_RD=3'd1`.
  - Grant encoding.
- Sub-module `ddr_addr_gen` (pointer, wrap, pending-load logic) is instantiated twice, once per port.

## Test plan
- Calibration gate: calib low, `wr_level=64`, `wr_bust_len=8` → no `app_en`. Raise calib → exactly 8 write accepts at addresses min, min+8, …, min+56, then IDLE.
- Address wrap: wr min=0, max=32, len=8, always ready → addresses 0, 8, 16, 24, 0, 8, 16, 24.
- Arbitration alternation: both ports permanently eligible, len=4 → bursts W,R,W,R. With the macro defined → W,W,W.
- Read-space guard: `rd_space=10`, len=8, `app_rd_data_valid` held off → one read burst, then no further read grant until valid returns ≥6 words.
- Backpressure plus mid-burst load: `app_wdf_rdy` toggling, plus a `wr_load` pulse mid-burst → `app_en` only in cycles where both readies are high; the burst completes from the old pointer, and the next burst starts at min.
- Reset mid-burst: `rst_n` low during RD_BURST → IDLE next cycle, all strobes 0, pointers = min.

Source files
------------

// File: rtl/ddr3_burst_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ddr_arb_pkg
// Shared types and constants for the DDR3 burst arbiter:
//   state_t : arbiter FSM states
//   grant_t : which requester was served most recently
//   CMD_WR / CMD_RD : DDR3 user-port command encodings
// ----------------------------------------------------------------------------
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2
    } state_t;

    typedef enum logic {
        GNT_WRITE = 1'b0,
        GNT_READ  = 1'b1
    } grant_t;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

endpackage

// File: rtl/ddr3_burst_arbiter_if.sv
// ----------------------------------------------------------------------------
// ddr3_burst_arbiter_if
// DDR3 IP user-port bundle between the arbiter and the memory interface top.
//   master : arbiter side (drives commands and write data)
//   slave  : memory-interface side (drives readies and read data)
// Signals: app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
//          app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
// ----------------------------------------------------------------------------
interface ddr3_burst_arbiter_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 256
);
    logic              app_rdy;
    logic              app_wdf_rdy;
    logic              app_rd_data_valid;
    logic [DATA_W-1:0] app_rd_data;

    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [DATA_W-1:0] app_wdf_data;

    modport master (
        input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
    );

    modport slave (
        output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
    );
endinterface

// File: rtl/ddr3_burst_arbiter_addr_gen.sv
// ----------------------------------------------------------------------------
// ddr_addr_gen
// Per-port wrapping address pointer with deferred rewind.
//   clk, rst_n          : clock, synchronous active-low reset
//   addr_min, addr_max  : live region bounds, region is [min, max)
//   load                : rewind request (one-cycle pulse)
//   active              : this port currently owns the burst
//   accept              : a command of this port was accepted this cycle
//   last                : the accept (if any) is the final one of the burst
//   ptr                 : current pointer
// ----------------------------------------------------------------------------
module ddr_addr_gen
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W    = 29,
    parameter int ADDR_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_min,
    input  logic [ADDR_W-1:0] addr_max,
    input  logic              load,
    input  logic              active,
    input  logic              accept,
    input  logic              last,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W:0] STEP_EXT = (ADDR_W+1)'(ADDR_STEP);

    logic [ADDR_W-1:0] min_q;
    logic [ADDR_W-1:0] max_q;
    logic              load_pend;
    logic [ADDR_W:0]   sum;
    logic [ADDR_W-1:0] next_ptr;

    // One extra bit so a pointer near the top of the address space cannot
    // overflow past max and escape the wrap test.
    always_comb begin
        sum = {1'b0, ptr} + STEP_EXT;
        if (sum >= {1'b0, max_q}) begin
            next_ptr = min_q;
        end else begin
            next_ptr = sum[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= addr_min;
            min_q     <= addr_min;
            max_q     <= addr_max;
            load_pend <= 1'b0;
        end else begin
            // Bounds track the inputs while idle, so the values present on
            // the grant edge are the ones frozen for the burst.
            if (!active) begin
                min_q <= addr_min;
                max_q <= addr_max;
            end

            if (!active) begin
                load_pend <= 1'b0;
                if (load) begin
                    ptr <= addr_min;
                end
            end else if (accept && last) begin
                // Leaving the burst: an outstanding or simultaneous rewind
                // takes precedence over the final increment.
                load_pend <= 1'b0;
                ptr       <= (load || load_pend) ? addr_min : next_ptr;
            end else begin
                if (load) begin
                    load_pend <= 1'b1;
                end
                if (accept) begin
                    ptr <= next_ptr;
                end
            end
        end
    end

endmodule

// File: rtl/ddr3_burst_arbiter.sv
// ----------------------------------------------------------------------------
// ddr3_burst_arbiter
// Shares the single DDR3 user port between a write FIFO (show-ahead) and a
// read FIFO. Issues bursts of single-beat commands with per-port wrapping
// addresses and never issues a read without room for its data.
//
// Ports:
//   ui_clk, rst_n                 : clock, synchronous active-low reset
//   init_calib_complete           : no grant while low
//   wr_load, rd_load              : rewind that port's pointer to its min
//   app_addr_{wr,rd}_{min,max}    : address regions [min, max)
//   wr_bust_len, rd_bust_len      : commands per burst, 0 disables the port
//   wr_level, wr_fifo_dout        : write FIFO fill level and head word
//   wr_fifo_rden                  : write FIFO pop
//   rd_space                      : free words in the read FIFO
//   rd_fifo_wren, rd_fifo_din     : registered read-data push
//   busy                          : FSM not idle
//   app                           : DDR3 user port (master modport)
//
// Build option: define DDR_ARB_WR_PRIORITY_EN to make write win every tie;
// otherwise ties alternate round-robin.
// ----------------------------------------------------------------------------
module ddr3_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 256,
    parameter int LVL_W     = 10,
    parameter int ADDR_STEP = 8
) (
    input  logic              ui_clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic [ADDR_W-1:0] app_addr_wr_min,
    input  logic [ADDR_W-1:0] app_addr_wr_max,
    input  logic [ADDR_W-1:0] app_addr_rd_min,
    input  logic [ADDR_W-1:0] app_addr_rd_max,
    input  logic [7:0]        wr_bust_len,
    input  logic [7:0]        rd_bust_len,
    input  logic [LVL_W-1:0]  wr_level,
    input  logic [DATA_W-1:0] wr_fifo_dout,
    output logic              wr_fifo_rden,
    input  logic [LVL_W-1:0]  rd_space,
    output logic              rd_fifo_wren,
    output logic [DATA_W-1:0] rd_fifo_din,
    output logic              busy,
    ddr3_burst_arbiter_if.master app
);

    localparam int               CW       = LVL_W + 2;
    localparam logic [LVL_W:0]   PEND_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        len_q;
    logic [7:0]        cnt;
    logic [LVL_W:0]    rd_pend;
    logic              wr_elig;
    logic              rd_elig;
    logic              wr_accept;
    logic              rd_accept;
    logic              burst_last;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

`ifndef DDR_ARB_WR_PRIORITY_EN
    grant_t            last_grant;
`endif

    // Reads also reserve room for data already requested but not returned.
    assign wr_elig = (wr_bust_len != 8'd0) && (CW'(wr_level) >= CW'(wr_bust_len));
    assign rd_elig = (rd_bust_len != 8'd0) &&
                     (CW'(rd_space) >= (CW'(rd_bust_len) + CW'(rd_pend)));

    assign wr_accept  = (state == ST_WR_BURST) && app.app_rdy && app.app_wdf_rdy;
    assign rd_accept  = (state == ST_RD_BURST) && app.app_rdy;
    assign burst_last = (cnt == (len_q - 8'd1));

    // State register
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (init_calib_complete) begin
                    if (wr_elig && rd_elig) begin
`ifdef DDR_ARB_WR_PRIORITY_EN
                        state_nxt = ST_WR_BURST;
`else
                        state_nxt = (last_grant == GNT_READ) ? ST_WR_BURST : ST_RD_BURST;
`endif
                    end else if (wr_elig) begin
                        state_nxt = ST_WR_BURST;
                    end else if (rd_elig) begin
                        state_nxt = ST_RD_BURST;
                    end
                end
            end
            ST_WR_BURST: begin
                if (wr_accept && burst_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_BURST: begin
                if (rd_accept && burst_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: every strobe is qualified by the accept condition so
    // app_en never rises on a cycle the memory does not take the command.
    always_comb begin
        app.app_en       = wr_accept || rd_accept;
        app.app_cmd      = (state == ST_RD_BURST) ? CMD_RD : CMD_WR;
        app.app_addr     = (state == ST_RD_BURST) ? rd_ptr : wr_ptr;
        app.app_wdf_wren = wr_accept;
        app.app_wdf_end  = wr_accept;
        app.app_wdf_data = wr_fifo_dout;
        wr_fifo_rden     = wr_accept;
        busy             = (state != ST_IDLE);
    end

    // Burst length is frozen at grant; the counter runs only inside a burst.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            cnt   <= 8'd0;
            len_q <= 8'd0;
        end else if (state == ST_IDLE) begin
            cnt <= 8'd0;
            if (state_nxt == ST_WR_BURST) begin
                len_q <= wr_bust_len;
            end else if (state_nxt == ST_RD_BURST) begin
                len_q <= rd_bust_len;
            end
        end else if (wr_accept || rd_accept) begin
            cnt <= cnt + 8'd1;
        end
    end

`ifndef DDR_ARB_WR_PRIORITY_EN
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            last_grant <= GNT_READ;
        end else if (state == ST_IDLE) begin
            if (state_nxt == ST_WR_BURST) begin
                last_grant <= GNT_WRITE;
            end else if (state_nxt == ST_RD_BURST) begin
                last_grant <= GNT_READ;
            end
        end
    end
`endif

    // Outstanding reads; saturates at both ends so a return after reset
    // (pend already 0) cannot underflow.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            rd_pend <= '0;
        end else begin
            unique case ({rd_accept, app.app_rd_data_valid})
                2'b10: if (rd_pend != PEND_MAX) rd_pend <= rd_pend + 1'b1;
                2'b01: if (rd_pend != '0)       rd_pend <= rd_pend - 1'b1;
                default: rd_pend <= rd_pend;
            endcase
        end
    end

    // Read data forwarding, one cycle behind the user port
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            rd_fifo_wren <= 1'b0;
            rd_fifo_din  <= '0;
        end else begin
            rd_fifo_wren <= app.app_rd_data_valid;
            rd_fifo_din  <= app.app_rd_data;
        end
    end

    ddr_addr_gen #(
        .ADDR_W    (ADDR_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_wr_addr (
        .clk      (ui_clk),
        .rst_n    (rst_n),
        .addr_min (app_addr_wr_min),
        .addr_max (app_addr_wr_max),
        .load     (wr_load),
        .active   (state == ST_WR_BURST),
        .accept   (wr_accept),
        .last     (burst_last),
        .ptr      (wr_ptr)
    );

    ddr_addr_gen #(
        .ADDR_W    (ADDR_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_rd_addr (
        .clk      (ui_clk),
        .rst_n    (rst_n),
        .addr_min (app_addr_rd_min),
        .addr_max (app_addr_rd_max),
        .load     (rd_load),
        .active   (state == ST_RD_BURST),
        .accept   (rd_accept),
        .last     (burst_last),
        .ptr      (rd_ptr)
    );

endmodule
